// File: rtl/alu_operand_recover_if.sv
// Handshake bundle for alu_operand_recover: ALU result stream in, recovered operand B stream out.
// The master modport is the environment side; the slave modport is the recovery block.
interface alu_operand_recover_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_res;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_b;
  logic             out_mode;
  logic             err;
  logic             err_clr;

  modport master (
    output in_valid, in_a, in_res, in_mode, out_ready, err_clr,
    input  in_ready, out_valid, out_b, out_mode, err
  );

  modport slave (
    input  in_valid, in_a, in_res, in_mode, out_ready, err_clr,
    output in_ready, out_valid, out_b, out_mode, err
  );
endinterface

// File: rtl/alu_operand_recover.sv
// Recovers ALU operand B from (A, result, mode) and buffers it in a 2-entry FIFO.
// Optional mode-sequence checking (alternating 0,1,0,1...) is enabled by defining ALU_INV_MODE_CHECK_EN.
module alu_operand_recover #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_recover_if.slave bus
);

  logic [WIDTH-1:0] mem_b [2];
  logic [1:0]       mem_mode;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             in_ready_q;
  logic [WIDTH-1:0] txn_count;
  logic [WIDTH-1:0] recovered;
  logic             push;
  logic             pop;

  // Add mode: res = a + b, so b = res - a. Subtract mode: res = a - b, so b = a - res.
  assign recovered = bus.in_mode ? (bus.in_res - bus.in_a) : (bus.in_a - bus.in_res);

  assign push = bus.in_valid & in_ready_q;
  assign pop  = (count != 2'd0) & bus.out_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // in_ready is a flop so it never depends combinationally on in_valid or out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      in_ready_q <= 1'b0;
      txn_count  <= '0;
    end else begin
      count      <= count_next;
      in_ready_q <= (count_next != 2'd2);
      if (push) begin
        wr_ptr    <= ~wr_ptr;
        txn_count <= txn_count + 1'b1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_b[0] <= '0;
      mem_b[1] <= '0;
      mem_mode <= 2'b00;
    end else if (push) begin
      mem_b[wr_ptr]    <= recovered;
      mem_mode[wr_ptr] <= bus.in_mode;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_b     = mem_b[rd_ptr];
  assign bus.out_mode  = mem_mode[rd_ptr];

`ifdef ALU_INV_MODE_CHECK_EN
  logic err_q;
  logic mismatch;

  // Expected mode alternates with the transfer count; a new mismatch wins over a clear.
  assign mismatch = push & (bus.in_mode != txn_count[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (mismatch) begin
      err_q <= 1'b1;
    end else if (bus.err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  logic unused_sink;
  assign unused_sink = ^{bus.err_clr, txn_count};

endmodule

// File: tb/tb_alu_operand_recover.sv
// Scoreboard bench for alu_operand_recover: driver pushes expected beats, monitor pops and compares.
module tb_alu_operand_recover;

  typedef struct {
    logic [7:0] b;
    logic       mode;
  } beat_t;

`ifdef ALU_INV_MODE_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic  clk;
  logic  rst;
  beat_t sb[$];
  int    assertCount;
  int    failCount;

  alu_operand_recover_if #(.WIDTH(8)) bus ();

  alu_operand_recover #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Offer one beat; record its hand-computed result when the DUT is seen ready.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] res, input logic mode,
                               input logic [7:0] exp_b);
    bit accepted;
    accepted     = 1'b0;
    bus.in_a     = a;
    bus.in_res   = res;
    bus.in_mode  = mode;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        sb.push_back(beat_t'{b: exp_b, mode: mode});
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL accept_timeout: got not_accepted expected accepted");
    end
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  // Monitor: compares the head every cycle out_valid is high, so stalls also check stability.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (sb.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_beat: got b=%0h expected no beat", bus.out_b);
        end else begin
          checkOutput("beat_b", bus.out_b, sb[0].b);
          checkOutput("beat_mode", bus.out_mode, sb[0].mode);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    assertCount   = 0;
    failCount     = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_res    = 8'h00;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_b", bus.out_b, 0);
    checkOutput("rst_out_mode", bus.out_mode, 0);
    checkOutput("rst_err", bus.err, 0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_before_edge", bus.in_ready, 0);
    @(negedge clk);
    checkOutput("in_ready_after_edge", bus.in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] basic recovery");
    bus.out_ready = 1'b1;
    applyStimulus(8'h10, 8'h15, 1'b1, 8'h05);
    @(negedge clk);
    checkOutput("latency_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    applyStimulus(8'h10, 8'h0B, 1'b0, 8'h05);
    applyStimulus(8'h01, 8'h00, 1'b1, 8'hFF);
    applyStimulus(8'h00, 8'h01, 1'b0, 8'hFF);
    applyStimulus(8'hF0, 8'h20, 1'b1, 8'h30);
    waitDrain();

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(8'h0A, 8'h1F, 1'b1, 8'h15);
    applyStimulus(8'h90, 8'h10, 1'b0, 8'h80);
    @(negedge clk);
    checkOutput("full_in_ready", bus.in_ready, 0);
    checkOutput("full_out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    fork
      applyStimulus(8'h33, 8'h30, 1'b1, 8'hFD);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] push and pop at occupancy 1");
    bus.out_ready = 1'b0;
    applyStimulus(8'h30, 8'h31, 1'b1, 8'h01);
    bus.out_ready = 1'b1;
    applyStimulus(8'h50, 8'h20, 1'b0, 8'h30);
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("occ1_out_valid", bus.out_valid, 1);
    checkOutput("occ1_in_ready", bus.in_ready, 1);
    checkOutput("occ1_head", bus.out_b, 8'h30);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    waitDrain();

    $display("[TB] reset with buffered beats");
    bus.out_ready = 1'b0;
    applyStimulus(8'h11, 8'h22, 1'b1, 8'h11);
    applyStimulus(8'h40, 8'h10, 1'b0, 8'h30);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("postrst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    $display("[TB] mode sequence");
    applyStimulus(8'h20, 8'h08, 1'b0, 8'h18);
    applyStimulus(8'h20, 8'h28, 1'b1, 8'h08);
    @(negedge clk);
    checkOutput("err_in_sequence", bus.err, 0);
    @(posedge clk);
    #1;
    applyStimulus(8'h03, 8'h05, 1'b1, 8'h02);
    @(negedge clk);
    checkOutput("err_after_mismatch", bus.err, ERR_EN);
    @(posedge clk);
    #1;
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    @(negedge clk);
    checkOutput("err_after_clr", bus.err, 0);
    @(posedge clk);
    #1;
    bus.err_clr = 1'b1;
    applyStimulus(8'h05, 8'h07, 1'b0, 8'hFE);
    bus.err_clr = 1'b0;
    @(negedge clk);
    checkOutput("err_clr_vs_mismatch", bus.err, ERR_EN);
    @(posedge clk);
    #1;
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    waitDrain();
    checkOutput("err_final", bus.err, 0);
    checkOutput("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
